// File: rtl/sound_level_meter.sv
// Peak-hold/decay level meter with thermometer LED bar and a hysteresis
// loud-event detector, fed by the saturated 0..64 PDM amplitude.
module sound_level_meter #(
    parameter int HOLD_CYCLES     = 65536,
    parameter int DECAY_DIV       = 4096,
    parameter int THR_ON          = 24,
    parameter int THR_OFF         = 12,
    parameter int COOLDOWN_CYCLES = 262144,
    parameter int LEDS            = 16
) (
    input  logic            M_CLK,
    input  logic            rst_i,
    input  logic [7:0]      amp_off_i,
    output logic [6:0]      peak_o,
    output logic [LEDS-1:0] bar_o,
    output logic            loud_o,
    output logic            event_o
);
    localparam int HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DW   = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam int CW   = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam int STEP = 64 / LEDS;

    localparam logic [1:0] QUIET = 2'd0;
    localparam logic [1:0] LOUD  = 2'd1;
    localparam logic [1:0] COOL  = 2'd2;

    if (THR_OFF >= THR_ON) begin : g_bad_thr
        $error("sound_level_meter: THR_OFF must be below THR_ON");
    end
    if (LEDS < 1 || LEDS > 64 || (LEDS & (LEDS - 1)) != 0) begin : g_bad_leds
        $error("sound_level_meter: LEDS must be a power of two in 1..64");
    end

    logic [6:0]    amp_q, amp_d;
    logic [6:0]    peak_q, peak_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [DW-1:0] decay_q, decay_d;
    logic [CW-1:0] cool_q, cool_d;
    logic [1:0]    state_q, state_d;
    logic          event_q, event_d;

    // Peak tracker: a new or equal level re-arms hold, then linear decay.
    always_comb begin
        amp_d   = (amp_off_i > 8'd64) ? 7'd64 : amp_off_i[6:0];
        peak_d  = peak_q;
        hold_d  = hold_q;
        decay_d = decay_q;
        if (amp_q >= peak_q) begin
            peak_d  = amp_q;
            hold_d  = HW'(HOLD_CYCLES - 1);
            decay_d = '0;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end else if (decay_q == DW'(DECAY_DIV - 1)) begin
            decay_d = '0;
            if (peak_q != 7'd0) peak_d = peak_q - 7'd1;
        end else begin
            decay_d = decay_q + DW'(1);
        end
    end

    // Re-trigger during cooldown returns to LOUD silently, ahead of expiry.
    always_comb begin
        state_d = state_q;
        cool_d  = cool_q;
        event_d = 1'b0;
        case (state_q)
            QUIET: if (amp_q >= 7'(THR_ON)) begin
                state_d = LOUD;
                event_d = 1'b1;
            end
            LOUD: if (amp_q < 7'(THR_OFF)) begin
                state_d = COOL;
                cool_d  = CW'(COOLDOWN_CYCLES - 1);
            end
            COOL: begin
                if (amp_q >= 7'(THR_ON)) state_d = LOUD;
                else if (cool_q == '0)   state_d = QUIET;
                else                     cool_d  = cool_q - CW'(1);
            end
            default: state_d = QUIET;
        endcase
    end

    always_ff @(posedge M_CLK) begin
        if (rst_i) begin
            amp_q   <= '0;
            peak_q  <= '0;
            hold_q  <= '0;
            decay_q <= '0;
            cool_q  <= '0;
            state_q <= QUIET;
            event_q <= 1'b0;
        end else begin
            amp_q   <= amp_d;
            peak_q  <= peak_d;
            hold_q  <= hold_d;
            decay_q <= decay_d;
            cool_q  <= cool_d;
            state_q <= state_d;
            event_q <= event_d;
        end
    end

    for (genvar k = 0; k < LEDS; k++) begin : g_bar
        assign bar_o[k] = (peak_q >= 7'((k + 1) * STEP));
    end

    assign peak_o  = peak_q;
    assign loud_o  = (state_q == LOUD);
    assign event_o = event_q;
endmodule

// File: tb/tb_sound_level_meter.sv
// Self-checking bench for sound_level_meter: directed scenarios plus a
// randomized run against a closed-form peak / deadline-based FSM model.
module tb_sound_level_meter;
    localparam int H = 8, D = 4, ON = 24, OFF = 12, C = 16, L = 16;

    logic          M_CLK = 1'b0;
    logic          rst_i = 1'b1;
    logic [7:0]    amp_off_i = '0;
    logic [6:0]    peak_o;
    logic [L-1:0]  bar_o;
    logic          loud_o, event_o;

    int checks = 0, errors = 0;

    // Model: peak as (level P, edges j since it was captured); FSM with a cooldown deadline.
    int m_amp, m_P, m_j, m_state, m_until, m_t;
    bit m_event;

    sound_level_meter #(.HOLD_CYCLES(H), .DECAY_DIV(D), .THR_ON(ON), .THR_OFF(OFF),
                        .COOLDOWN_CYCLES(C), .LEDS(L)) dut (
        .M_CLK(M_CLK), .rst_i(rst_i), .amp_off_i(amp_off_i),
        .peak_o(peak_o), .bar_o(bar_o), .loud_o(loud_o), .event_o(event_o));

    always #5 M_CLK = ~M_CLK;

    function automatic int f_peak(input int P, input int j);
        int d;
        if (j < H - 1) return P;
        d = (j - H + 1) / D;
        return (P > d) ? P - d : 0;
    endfunction

    function automatic logic [L-1:0] f_bar(input int pk);
        int n;
        n = pk / (64 / L);
        return L'((33'd1 << n) - 33'd1);
    endfunction

    task automatic cyc(input int a, input bit r);
        int cur;
        amp_off_i = 8'(a);
        rst_i = r;
        @(posedge M_CLK);
        if (r) begin
            m_amp = 0; m_P = 0; m_j = 1000; m_state = 0; m_event = 0;
        end else begin
            cur = f_peak(m_P, m_j);
            if (m_amp >= cur) begin m_P = m_amp; m_j = 0; end
            else if (m_j < 100000) m_j++;
            m_event = 0;
            case (m_state)
                0: if (m_amp >= ON) begin m_state = 1; m_event = 1; end
                1: if (m_amp < OFF) begin m_state = 2; m_until = m_t + C; end
                default: if (m_amp >= ON) m_state = 1;
                         else if (m_t >= m_until) m_state = 0;
            endcase
            m_amp = (a > 64) ? 64 : a;
        end
        m_t++;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(64, 1'b1);
            checks++;
            if ({peak_o, bar_o, loud_o, event_o} !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got peak=%0d bar=%h loud=%b ev=%b want all 0",
                         i, peak_o, bar_o, loud_o, event_o);
            end
        end
        cyc(64, 1'b0);
        checks++;
        if ({peak_o, bar_o, loud_o, event_o} !== '0) begin
            errors++;
            $display("FAIL reset_release got peak=%0d bar=%h loud=%b ev=%b want all 0",
                     peak_o, bar_o, loud_o, event_o);
        end
    endtask

    task automatic test_hold_decay();
        cyc(0, 1'b1); cyc(0, 1'b1);
        cyc(40, 1'b0); cyc(0, 1'b0);
        checks++;
        if (peak_o !== 7'd40 || bar_o !== 16'h03FF) begin
            errors++;
            $display("FAIL capture got peak=%0d bar=%h want 40 03ff", peak_o, bar_o);
        end
        repeat (10) cyc(0, 1'b0);
        checks++;
        if (peak_o !== 7'd40) begin
            errors++;
            $display("FAIL hold_end got %0d want 40", peak_o);
        end
        cyc(0, 1'b0);
        checks++;
        if (peak_o !== 7'd39) begin
            errors++;
            $display("FAIL first_decay got %0d want 39", peak_o);
        end
        repeat (4) cyc(0, 1'b0);
        checks++;
        if (peak_o !== 7'd38 || bar_o !== 16'h01FF) begin
            errors++;
            $display("FAIL decay_step got peak=%0d bar=%h want 38 01ff", peak_o, bar_o);
        end
        repeat (160) cyc(0, 1'b0);
        checks++;
        if (peak_o !== 7'd0 || bar_o !== 16'h0000) begin
            errors++;
            $display("FAIL decay_floor got peak=%0d bar=%h want 0 0000", peak_o, bar_o);
        end
    endtask

    task automatic test_saturation();
        cyc(0, 1'b1);
        cyc(200, 1'b0); cyc(200, 1'b0);
        checks++;
        if (peak_o !== 7'd64 || bar_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturate got peak=%0d bar=%h want 64 ffff", peak_o, bar_o);
        end
        repeat (20) cyc(64, 1'b0);
        checks++;
        if (peak_o !== 7'd64) begin
            errors++;
            $display("FAIL equal_rearm got %0d want 64", peak_o);
        end
    endtask

    task automatic test_hysteresis();
        int ev;
        cyc(0, 1'b1);
        cyc(30, 1'b0);
        checks++;
        if (loud_o !== 1'b0 || event_o !== 1'b0) begin
            errors++;
            $display("FAIL hyst_early got loud=%b ev=%b want 0 0", loud_o, event_o);
        end
        cyc(30, 1'b0);
        checks++;
        if (loud_o !== 1'b1 || event_o !== 1'b1) begin
            errors++;
            $display("FAIL hyst_enter got loud=%b ev=%b want 1 1", loud_o, event_o);
        end
        ev = 0;
        repeat (5) begin cyc(18, 1'b0); ev += int'(event_o); end
        checks++;
        if (loud_o !== 1'b1 || ev != 0) begin
            errors++;
            $display("FAIL hyst_band got loud=%b events=%0d want 1 0", loud_o, ev);
        end
        cyc(5, 1'b0); cyc(5, 1'b0);
        checks++;
        if (loud_o !== 1'b0) begin
            errors++;
            $display("FAIL hyst_cool got loud=%b want 0", loud_o);
        end
        repeat (3) cyc(5, 1'b0);
        ev = 0;
        repeat (3) begin cyc(30, 1'b0); ev += int'(event_o); end
        checks++;
        if (loud_o !== 1'b1 || ev != 0) begin
            errors++;
            $display("FAIL hyst_retrig got loud=%b events=%0d want 1 0", loud_o, ev);
        end
    endtask

    // Starts in LOUD; checks the last cycle of cooldown and the first after it.
    task automatic test_cooldown();
        int ev;
        cyc(0, 1'b0); cyc(0, 1'b0);
        repeat (14) cyc(0, 1'b0);
        ev = 0;
        repeat (3) begin cyc(24, 1'b0); ev += int'(event_o); end
        checks++;
        if (loud_o !== 1'b1 || ev != 0) begin
            errors++;
            $display("FAIL cool_inside got loud=%b events=%0d want 1 0", loud_o, ev);
        end
        cyc(0, 1'b0); cyc(0, 1'b0);
        repeat (15) cyc(0, 1'b0);
        ev = 0;
        repeat (4) begin cyc(24, 1'b0); ev += int'(event_o); end
        checks++;
        if (loud_o !== 1'b1 || ev != 1) begin
            errors++;
            $display("FAIL cool_expired got loud=%b events=%0d want 1 1", loud_o, ev);
        end
        repeat (22) cyc(0, 1'b0);
        ev = 0;
        repeat (5) begin cyc(23, 1'b0); ev += int'(event_o); end
        checks++;
        if (loud_o !== 1'b0 || ev != 0) begin
            errors++;
            $display("FAIL quiet_23 got loud=%b events=%0d want 0 0", loud_o, ev);
        end
    endtask

    task automatic test_reset_mid();
        int ev;
        cyc(0, 1'b1);
        cyc(30, 1'b0); cyc(30, 1'b0);
        repeat (12) cyc(0, 1'b0);
        checks++;
        if (loud_o !== 1'b0 || peak_o !== 7'd29) begin
            errors++;
            $display("FAIL mid_setup got loud=%b peak=%0d want 0 29", loud_o, peak_o);
        end
        cyc(0, 1'b1);
        checks++;
        if ({peak_o, bar_o, loud_o, event_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset got peak=%0d bar=%h loud=%b ev=%b want all 0",
                     peak_o, bar_o, loud_o, event_o);
        end
        ev = 0;
        repeat (3) begin cyc(30, 1'b0); ev += int'(event_o); end
        checks++;
        if (ev != 1 || peak_o !== 7'd30) begin
            errors++;
            $display("FAIL fresh_event got events=%0d peak=%0d want 1 30", ev, peak_o);
        end
    endtask

    task automatic test_random();
        int a, sel;
        bit r;
        cyc(0, 1'b1);
        for (int i = 0; i < 500; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)     a = $urandom_range(0, 255);
            else if (sel < 4) a = $urandom_range(0, 11);
            else if (sel < 7) a = $urandom_range(12, 30);
            else              a = $urandom_range(0, 5);
            r = ($urandom_range(0, 79) == 0);
            cyc(a, r);
            checks++;
            if (peak_o !== 7'(f_peak(m_P, m_j)) || bar_o !== f_bar(f_peak(m_P, m_j))) begin
                errors++;
                $display("FAIL rand_peak cyc %0d got peak=%0d bar=%h want %0d %h",
                         i, peak_o, bar_o, f_peak(m_P, m_j), f_bar(f_peak(m_P, m_j)));
            end
            checks++;
            if (loud_o !== (m_state == 1) || event_o !== m_event) begin
                errors++;
                $display("FAIL rand_fsm cyc %0d got loud=%b ev=%b want %b %b",
                         i, loud_o, event_o, (m_state == 1), m_event);
            end
        end
    endtask

    initial begin
        m_t = 0; m_until = 0;
        test_reset();
        test_hold_decay();
        test_saturation();
        test_hysteresis();
        test_cooldown();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
